cla16_mp_sequencer: RTL and testbench

//  Multi-precision adder sequencer that sits directly in front of the 16-bit CLA.

---
 rtl/cla16_mp_sequencer_if.sv | 23 ++
 rtl/cla16_mp_sequencer.sv | 63 ++++++
 tb/tb_cla16_mp_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cla16_mp_sequencer_if.sv
// cla16_mp_sequencer_if: request/result and CLA slice signals of the multi-precision adder sequencer
interface cla16_mp_sequencer_if #(parameter int WORDS = 4);
  logic             start;
  logic [WORDS*16-1:0] op_a;
  logic [WORDS*16-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WORDS*16-1:0] result;
  logic             cout;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic             add_cin;
  logic [16:0]      add_sum;
  modport master (
    output start, op_a, op_b, cin, add_sum,
    input  busy, done, result, cout, add_a, add_b, add_cin
  );
  modport slave (
    input  start, op_a, op_b, cin, add_sum,
    output busy, done, result, cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/cla16_mp_sequencer.sv
// cla16_mp_sequencer: adds two WORDS*16-bit operands one 16-bit slice per cycle through an external CLA
module cla16_mp_sequencer #(
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst,
  cla16_mp_sequencer_if.slave bus
);
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  logic [WORDS-1:0][15:0] a_q, b_q, result_q;
  logic                   carry_q, cout_q, busy_q, done_q;
  logic                   last;
  assign last = idx_q == IW'(WORDS - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RUN) begin
        result_q[idx_q] <= bus.add_sum[15:0];
        carry_q         <= bus.add_sum[16];
        if (last) begin
          cout_q  <= bus.add_sum[16];
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end else if (bus.start) begin
        a_q      <= bus.op_a;
        b_q      <= bus.op_b;
        carry_q  <= bus.cin;
        idx_q    <= '0;
        result_q <= '0;
        cout_q   <= 1'b0;
        state_q  <= RUN;
        busy_q   <= 1'b1;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  // busy_q tracks RUN exactly, so it gates the slice drive without touching start/op_*
  assign bus.add_a   = busy_q ? a_q[idx_q] : 16'd0;
  assign bus.add_b   = busy_q ? b_q[idx_q] : 16'd0;
  assign bus.add_cin = busy_q & carry_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
endmodule

// File: tb/tb_cla16_mp_sequencer.sv
// tb_cla16_mp_sequencer: directed and back-to-back random adds checked against an arithmetic model
module tb_cla16_mp_sequencer;
  localparam int W = 4;
  localparam int N = W * 16;
  typedef logic [N:0] w_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cla16_mp_sequencer_if #(.WORDS(W)) bus();
  cla16_mp_sequencer #(.WORDS(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};
  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;
  task automatic chk(input string nm, input w_t act, input w_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // model: age = edges since the last accepted start; 100 means idle
  logic [N-1:0] ma = '0, mb = '0;
  logic mc = 1'b0;
  w_t msum = '0;
  int age = 100;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = 100; ma = '0; mb = '0; mc = 1'b0; msum = '0;
    end else if (bus.start && age >= W) begin
      ma = bus.op_a; mb = bus.op_b; mc = bus.cin;
      msum = w_t'(bus.op_a) + w_t'(bus.op_b) + w_t'(bus.cin);
      age = 0;
    end else if (age < 100) age++;
  end
  always @(negedge clk) begin
    int k;
    w_t m;
    bit b;
    if (cmp_en && !rst) begin
      b = age < W;
      k = b ? age : W;
      m = (w_t'(1) << (k * 16)) - w_t'(1);
      chk("busy", w_t'(bus.busy), w_t'(b));
      chk("done", w_t'(bus.done), w_t'(age == W));
      chk("result", w_t'(bus.result), msum & m);
      chk("cout", w_t'(bus.cout), w_t'(age >= W ? msum[N] : 1'b0));
      chk("add_a", w_t'(bus.add_a), w_t'(b ? ma[(b ? k : 0) * 16 +: 16] : 16'd0));
      chk("add_b", w_t'(bus.add_b), w_t'(b ? mb[(b ? k : 0) * 16 +: 16] : 16'd0));
      chk("add_cin", w_t'(bus.add_cin),
          b ? (((w_t'(ma) & m) + (w_t'(mb) & m) + w_t'(mc)) >> (k * 16)) & w_t'(1) : w_t'(0));
    end
  end
  logic [N-1:0] res_r;
  logic cout_r;
  int lat, nbusy;
  logic [15:0] seq_a [W];
  logic seq_cin [W];
  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input bit inj);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.cin = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; nbusy = 0; res_r = '0; cout_r = 1'b0;
    for (int i = 0; i < 12 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        if (nbusy < W) begin
          seq_a[nbusy] = bus.add_a;
          seq_cin[nbusy] = bus.add_cin;
        end
        nbusy++;
      end
      if (bus.done) begin
        lat = i; res_r = bus.result; cout_r = bus.cout;
      end
      if (inj && i == 1) begin
        bus.start = 1'b1; bus.op_a = ~a; bus.op_b = a; bus.cin = 1'b1;
      end
      if (inj && i == 2) bus.start = 1'b0;
    end
    if (lat < 0) begin
      checks++;
      $display("FAIL done_timeout: no done within 12 cycles, expected after 4");
    end
  endtask
  logic [N-1:0] ra, rb;
  logic rc;
  int cnt, ndone;
  initial begin
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", w_t'(bus.busy), w_t'(0));
    chk("rst done", w_t'(bus.done), w_t'(0));
    chk("rst result", w_t'(bus.result), w_t'(0));
    chk("rst add_a", w_t'(bus.add_a), w_t'(0));
    rst = 1'b0;
    cmp_en = 1'b1;
    run({N{1'b1}}, 64'd1, 1'b0, 1'b0);
    chk("t1 result", w_t'(res_r), w_t'(0));
    chk("t1 cout", w_t'(cout_r), w_t'(1));
    chk("t1 latency", w_t'(lat), w_t'(4));
    chk("t1 busy cycles", w_t'(nbusy), w_t'(4));
    run(64'd0, 64'd0, 1'b1, 1'b0);
    chk("t2 result", w_t'(res_r), w_t'(1));
    chk("t2 cout", w_t'(cout_r), w_t'(0));
    chk("t2 add_cin seq", w_t'({seq_cin[3], seq_cin[2], seq_cin[1], seq_cin[0]}), w_t'(4'b0001));
    run(64'h0000_0000_8000_8000, 64'h0000_0000_8000_8000, 1'b0, 1'b0);
    chk("t3 result", w_t'(res_r), w_t'(64'h0000_0001_0001_0000));
    chk("t3 cout", w_t'(cout_r), w_t'(0));
    chk("t3 add_a seq", w_t'({seq_a[0], seq_a[1], seq_a[2], seq_a[3]}), w_t'(64'h8000_8000_0000_0000));
    run(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1);
    chk("t4 result", w_t'(res_r), w_t'(64'h2345_6789_ABCD_F001));
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t4 extra done", w_t'(ndone), w_t'(0));
    chk("t4 result held", w_t'(bus.result), w_t'(64'h2345_6789_ABCD_F001));
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = 64'hFFFF; bus.op_b = 64'h1; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5 rst busy", w_t'(bus.busy), w_t'(0));
    chk("t5 rst result", w_t'(bus.result), w_t'(0));
    chk("t5 rst done", w_t'(bus.done), w_t'(0));
    @(posedge clk); #1 rst = 1'b0;
    run(64'd5, 64'd7, 1'b0, 1'b0);
    chk("t5 result", w_t'(res_r), w_t'(12));
    @(posedge clk); #1;
    ra = {N{1'b1}}; rb = 64'd1; rc = 1'b1;
    bus.start = 1'b1; bus.op_a = ra; bus.op_b = rb; bus.cin = rc;
    for (int j = 0; j < 200; j++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus.done && cnt < 12);
      if (!bus.done) begin
        checks++;
        $display("FAIL t6 done_timeout: no done within 12 cycles at add %0d", j);
        break;
      end
      chk("t6 sum", {bus.cout, bus.result}, w_t'(ra) + w_t'(rb) + w_t'(rc));
      if (j > 0) chk("t6 spacing", w_t'(cnt), w_t'(5));
      ra = (j % 4 == 2) ? {N{1'b1}} : {$urandom, $urandom};
      rb = (j % 5 == 3) ? '0 : {$urandom, $urandom};
      rc = 1'($urandom);
      bus.op_a = ra; bus.op_b = rb; bus.cin = rc;
    end
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
